// File: rtl/clint_timer.sv
// Core-local interruptor timer block: 64-bit mtime with prescaler, mtimecmp compare
// driving mtip, and a software interrupt bit msip, behind a single-cycle memory port.
module clint_timer #(
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [31:0] ADDR_MASK = 32'h0000FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mtip,
  output logic        msip
);

  localparam logic [31:0] OFF_MSIP   = 32'h0000_0000;
  localparam logic [31:0] OFF_CMP_LO = 32'h0000_4000;
  localparam logic [31:0] OFF_CMP_HI = 32'h0000_4004;
  localparam logic [31:0] OFF_MT_LO  = 32'h0000_BFF8;
  localparam logic [31:0] OFF_MT_HI  = 32'h0000_BFFC;
  localparam logic [15:0] DIV_LAST   = 16'(TICK_DIV - 1);

  logic [31:0] offset;
  logic [31:0] wmask;
  logic [31:0] rd_mux;
  logic        is_wr, is_rd;
  logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic        mt_wr, tick;
  logic [15:0] presc;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip_bit;

  assign offset     = mem_addr & ADDR_MASK;
  assign is_wr      = mem_valid && (mem_wstrb != 4'b0000);
  assign is_rd      = mem_valid && (mem_wstrb == 4'b0000);
  assign sel_msip   = (offset == OFF_MSIP);
  assign sel_cmp_lo = (offset == OFF_CMP_LO);
  assign sel_cmp_hi = (offset == OFF_CMP_HI);
  assign sel_mt_lo  = (offset == OFF_MT_LO);
  assign sel_mt_hi  = (offset == OFF_MT_HI);
  assign mt_wr      = is_wr && (sel_mt_lo || sel_mt_hi);
  assign tick       = (presc == DIV_LAST);

  // Byte strobes expanded to a bit mask so every register write is one merge.
  genvar b;
  generate
    for (b = 0; b < 4; b++) begin : g_lane
      assign wmask[8*b +: 8] = {8{mem_wstrb[b]}};
    end
  endgenerate

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [31:0] msk);
    return (old & ~msk) | (nw & msk);
  endfunction

  // A software write to mtime wins over the tick and restarts the prescale period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      mtime <= '0;
    end else if (mt_wr) begin
      presc <= '0;
      if (sel_mt_lo) mtime[31:0]  <= merge(mtime[31:0], mem_wdata, wmask);
      if (sel_mt_hi) mtime[63:32] <= merge(mtime[63:32], mem_wdata, wmask);
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      if (tick) mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
      msip_bit <= 1'b0;
    end else if (is_wr) begin
      if (sel_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], mem_wdata, wmask);
      if (sel_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], mem_wdata, wmask);
      if (sel_msip && mem_wstrb[0]) msip_bit <= mem_wdata[0];
    end
  end

  // Compare uses the current registers, so mtip trails any change by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mtip <= 1'b0;
    else      mtip <= (mtime >= mtimecmp);
  end

  assign msip = msip_bit;

  always_comb begin
    rd_mux = '0;
    case (1'b1)
      sel_msip:   rd_mux = {31'd0, msip_bit};
      sel_cmp_lo: rd_mux = mtimecmp[31:0];
      sel_cmp_hi: rd_mux = mtimecmp[63:32];
      sel_mt_lo:  rd_mux = mtime[31:0];
      sel_mt_hi:  rd_mux = mtime[63:32];
      default:    rd_mux = '0;
    endcase
  end

  // Response is registered; rdata is forced to zero on any non-read cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= mem_valid;
      mem_rdata <= is_rd ? rd_mux : 32'd0;
    end
  end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 Parameter TICK_DIV, default 1, is the number of clk cycles per mtime increment; legal range 1..65535.
REQ-002 Parameter ADDR_MASK, default 32'h0000FFFF, selects the address bits used for register decode.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 mem_valid  input  1  bus request strobe.
REQ-006 mem_addr  input  32  byte address; decoded as (mem_addr & ADDR_MASK).
REQ-007 mem_wdata  input  32  write data.
REQ-008 mem_wstrb  input  4  byte write enables; all-zero means read.
REQ-009 mem_ready  output  1  one-cycle response strobe.
REQ-010 mem_rdata  output  32  read data, valid while mem_ready=1, otherwise 0.
REQ-011 mtip  output  1  machine timer interrupt pending; drives the CSR block's mip[7] input.
REQ-012 msip  output  1  machine software interrupt pending; drives the CSR block's mip[3] input.

Function
REQ-013 Register map (decoded offset): 0x0000 msip (bit0 only, other bits read 0); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-014 Write: on a mem_valid cycle with mem_wstrb!=0, each byte lane i with mem_wstrb[i]=1 updates the addressed register's byte i at the next edge.
REQ-015 Read: on a mem_valid cycle with mem_wstrb=0, the addressed register value is captured and presented on mem_rdata in the next cycle.
REQ-016 Handshake: mem_ready=1 exactly one cycle after every cycle with mem_valid=1, for reads and writes, with no stalls; back-to-back requests produce back-to-back ready pulses.
REQ-017 Unmapped offsets: writes ignored, read data 0, mem_ready still asserted.
REQ-018 Prescaler: a 16-bit counter counts 0..TICK_DIV-1 and wraps to 0; mtime increments by 1 in the cycle the counter equals TICK_DIV-1.
REQ-019 mtime is 64-bit and wraps from 2^64-1 to 0 without a flag.
REQ-020 A 32-bit increment carries into mtime[63:32] in the same cycle.
REQ-021 A bus write to either mtime half takes priority over that cycle's increment: the written bytes take the new data, and no increment occurs in that cycle for either half.
REQ-022 A bus write to mtime resets the prescaler counter to 0.
REQ-023 mtip is a register, updated every cycle to (mtime >= mtimecmp), unsigned 64-bit compare, using current register values (one cycle latency after any change).
REQ-024 msip equals the msip register bit0 directly.
REQ-025 A read of mtime returns the value before any increment in the same edge; 64-bit coherence across two 32-bit reads is software's responsibility (hi-lo-hi loop).
REQ-026 A read and a write never occur in the same request; wstrb selects the operation.

Reset
REQ-027 While rst=0, regardless of clk: mtime=0, mtimecmp=64'hFFFFFFFF_FFFFFFFF, msip=0, prescaler=0, mtip=0, mem_ready=0, mem_rdata=0.
REQ-028 Reset asserted mid-transaction drops any pending response; no mem_ready is issued for a request accepted before or during reset.
REQ-029 In the first cycle after reset release, mtime starts counting and mtip remains 0 (compare with the all-ones mtimecmp).

Verification
REQ-030 Reset release with TICK_DIV=1, idle for 10 cycles -> read 0xBFF8 returns 10 (+/-1 for the read cycle per REQ-025), mtip=0.
REQ-031 Write mtimecmp lo=20, hi=0; write mtime lo=0 -> mtip rises exactly one cycle after mtime reaches 20, stays 1; then write mtimecmp hi=1 -> mtip falls one cycle later.
REQ-032 Write mtime lo=32'hFFFFFFFF, hi=0, TICK_DIV=1 -> next cycle mtime={32'h1,32'h0}; write mtime hi=32'hFFFFFFFF, lo=32'hFFFFFFFF -> wraps to 0.
REQ-033 TICK_DIV=4: mtime increments once per 4 clk cycles; a mtime write in mid-period restarts the 4-cycle count.
REQ-034 Write 0x0000 with wstrb=4'b0001 data=1 -> msip=1 next cycle; write with wstrb=4'b0010 data=1 -> msip unchanged; read 0x1234 -> rdata 0, ready 1.
REQ-035 Assert rst low while mem_valid=1 and mtime=100 -> all outputs 0 immediately, no ready after release, mtimecmp reads all-ones.
